dmx_frame_sequencer: RTL and testbench
======================================

// Module: dmx_frame_sequencer
// PURPOSE
//  Sequences one DMX512 frame per request: BREAK, MARK-AFTER-BREAK, start code, then N slot bytes.
//  Slot bytes are read from the channel RAM and handed to the 250 kbaud 8N2 byte serializer that drives TX.
//  Sits between the refresh-rate tick (30/40 Hz domain, resynchronised to one-cycle pulses) and the TX serializer/mux.
//  Runs entirely on the internal oscillator clock.
// PARAMETERS
//  CLK_FREQ   12090000  clk_In frequency, Hz
//  BREAK_US   176       BREAK length, us; BREAK_CYC = (CLK_FREQ/1000)*BREAK_US/1000, rounded down = 2127
//  MAB_US     12        MAB length, us; MAB_CYC = (CLK_FREQ/1000)*MAB_US/1000, rounded down = 145
//  NUM_SLOTS  512       maximum data slots per frame
// PORTS
//  clk_In          in   1   system clock (12.09 MHz)
//  rst_n           in   1   asynchronous active-low reset
//  enable          in   1   1 = accept frame requests
//  frame_tick      in   1   one-cycle frame request pulse
//  start_code      in   8   start code, latched at frame start
//  slot_count      in   10  data slots per frame, latched at frame start; 0 or >NUM_SLOTS => NUM_SLOTS
//  ram_rd          out  1   channel RAM read strobe
//  ram_addr        out  9   channel RAM address (slot index, 0-based)
//  ram_data        in   8   RAM read data, valid the cycle after ram_rd
//  tx_data         out  8   byte to serializer
//  tx_valid        out  1   byte valid
//  tx_ready        in   1   serializer idle/accepting; high only after previous byte's stop bits finish
//  line_force_low  out  1   1 = TX mux drives line low (BREAK)
//  busy            out  1   frame in progress (any state but IDLE)
//  frame_done      out  1   one-cycle pulse: last slot byte accepted
//  overrun         out  1   one-cycle pulse: frame_tick dropped because busy
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0; counters and latches cleared; pending request cleared.
//  States: IDLE, BREAK, MAB, START, FETCH, LOAD, SEND.
//  IDLE: frame_tick&enable sets pending; frame_tick with enable=0 is ignored (no overrun).
//   pending & tx_ready -> BREAK next cycle; latch start_code and clamped slot_count; clear pending.
//   With tx_ready=1 at the tick: BREAK entered at T+1.
//  BREAK: line_force_low=1 for exactly BREAK_CYC cycles -> MAB.
//  MAB: line_force_low=0, tx_valid=0, for exactly MAB_CYC cycles -> START.
//  START: tx_data=start_code, tx_valid=1. Transfer = tx_valid&tx_ready; on transfer -> FETCH, slot index=0.
//  FETCH: ram_rd=1 (one cycle), ram_addr=slot index -> LOAD.
//  LOAD: capture ram_data into tx_data -> SEND.
//  SEND: tx_valid=1, tx_data stable until transfer. On transfer:
//   - index<count-1: index++ -> FETCH
//   - index=count-1: frame_done=1 that cycle -> IDLE
//  Valid rule: tx_valid never drops and tx_data never changes before transfer.
//  Index counter: 10 bits; ram_addr = index[8:0]; no wrap (max 511).
//  enable is sampled in IDLE only; deasserting mid-frame lets the frame complete.
//  frame_tick while busy or while pending: dropped; overrun pulses the following cycle; running frame unaffected.
//  Simultaneous frame_done and frame_tick: tick counts as busy -> overrun.
//  busy=1 from the BREAK entry cycle through the frame_done cycle inclusive.
//  Timer width: $clog2(BREAK_CYC+1); one shared down-counter for BREAK and MAB.
// TESTING
//  T1 slot_count=3, start_code=0x00, RAM[0..2]=AA,55,FF, tx_ready=1, tick
//     -> line_force_low high 2127 cycles, then 145 cycles low/idle
//     -> bytes 00,AA,55,FF; ram_addr 0,1,2; one frame_done; busy then falls
//  T2 T1 with tx_ready held 0 for 50 cycles during slot 1
//     -> tx_valid held 1, tx_data=AA stable, no byte lost or duplicated
//  T3 second tick 1000 cycles into a frame -> overrun pulse 1 cycle; frame completes once; no restart
//  T4 slot_count=0, then 600 -> 512 slot bytes each, last ram_addr=511, frame_done once each
//  T5 rst_n low mid-MAB -> all outputs 0 asynchronously; after release, a tick yields a full correct frame
//  T6 enable=0 + tick -> nothing, no overrun; enable dropped mid-frame -> frame still completes

Source files
------------

// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame sequencer: BREAK, MARK-AFTER-BREAK, start code, then slot bytes fetched
// from the channel RAM and handed byte-by-byte to the TX serializer.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a frame request and an idle serializer
//  S_BREAK | line held low for BREAK_CYC cycles
//  S_MAB   | line released, nothing sent, for MAB_CYC cycles
//  S_START | start code offered to serializer until accepted
//  S_FETCH | one-cycle RAM read of the current slot
//  S_LOAD  | RAM data captured into the TX byte register
//  S_SEND  | slot byte offered until accepted; last slot ends the frame
module dmx_frame_sequencer #(
  parameter int CLK_FREQ  = 12090000,
  parameter int BREAK_US  = 176,
  parameter int MAB_US    = 12,
  parameter int NUM_SLOTS = 512
) (
  input  logic       clk_In,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] start_code,
  input  logic [9:0] slot_count,
  output logic       ram_rd,
  output logic [8:0] ram_addr,
  input  logic [7:0] ram_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       line_force_low,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int BREAK_CYC = (CLK_FREQ / 1000) * BREAK_US / 1000;
  localparam int MAB_CYC   = (CLK_FREQ / 1000) * MAB_US / 1000;
  localparam int TW        = $clog2(BREAK_CYC + 1);

  localparam logic [TW-1:0] BREAK_LD  = TW'(BREAK_CYC - 1);
  localparam logic [TW-1:0] MAB_LD    = TW'(MAB_CYC - 1);
  localparam logic [9:0]    MAX_SLOTS = 10'(NUM_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_MAB, S_START, S_FETCH, S_LOAD, S_SEND
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    idx_q, idx_d;
  logic [9:0]    count_q, count_d;
  logic [7:0]    sc_q, sc_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          req;
  logic [9:0]    count_clamped;

  assign count_clamped = (slot_count == 10'd0 || slot_count > MAX_SLOTS) ? MAX_SLOTS : slot_count;
  assign req           = pending_q | (frame_tick & enable);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    count_d    = count_q;
    sc_d       = sc_q;
    tx_data_d  = tx_data_q;
    pending_d  = pending_q;
    frame_done = 1'b0;
    // a tick that cannot start a frame on its own is reported the following cycle
    overrun_d  = frame_tick & ((state_q != S_IDLE) | pending_q);

    case (state_q)
      S_IDLE: begin
        if (req && tx_ready) begin
          state_d   = S_BREAK;
          timer_d   = BREAK_LD;
          sc_d      = start_code;
          count_d   = count_clamped;
          idx_d     = 10'd0;
          pending_d = 1'b0;
        end else if (frame_tick && enable) begin
          pending_d = 1'b1;
        end
      end
      S_BREAK: begin
        if (timer_q == '0) begin
          state_d = S_MAB;
          timer_d = MAB_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_MAB: begin
        if (timer_q == '0) begin
          state_d   = S_START;
          tx_data_d = sc_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_START: begin
        if (tx_ready) begin
          state_d = S_FETCH;
          idx_d   = 10'd0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tx_data_d = ram_data;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == count_q - 10'd1) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_In or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      sc_q      <= '0;
      tx_data_q <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      sc_q      <= sc_d;
      tx_data_q <= tx_data_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign line_force_low = (state_q == S_BREAK);
  assign ram_rd         = (state_q == S_FETCH);
  assign ram_addr       = idx_q[8:0];
  assign tx_valid       = (state_q == S_START) || (state_q == S_SEND);
  assign tx_data        = tx_data_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Randomized bench for dmx_frame_sequencer; every frame is compared against the byte and
// timing sequence a DMX frame must have, derived from start code, slot count and RAM image.
`timescale 1ns/1ps
module tb_dmx_frame_sequencer;
  localparam int BREAK_CYC = 2127;
  localparam int MAB_CYC   = 145;
  localparam int NSLOT     = 512;

  logic       clk_In = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] start_code = '0;
  logic [9:0] slot_count = '0;
  logic       ram_rd;
  logic [8:0] ram_addr;
  logic [7:0] ram_data = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       line_force_low, busy, frame_done, overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [NSLOT];
  logic [7:0] bytes_q [$];
  int         addr_q [$];
  int         brk_cnt, mab_cnt, done_cnt, ovr_cnt, viol;
  bit         seen_start;
  bit         hold_low = 1'b0;
  bit         force_rdy = 1'b0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  dmx_frame_sequencer dut (
    .clk_In(clk_In), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick),
    .start_code(start_code), .slot_count(slot_count),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .line_force_low(line_force_low), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk_In = ~clk_In;

  // channel RAM: data valid the cycle after a read, garbage otherwise
  always @(posedge clk_In) ram_data <= ram_rd ? ram[ram_addr] : 8'($urandom);

  initial forever begin
    @(posedge clk_In);
    #2;
    tx_ready = hold_low ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
  end

  always @(negedge clk_In) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (line_force_low) brk_cnt++;
      if (busy && !line_force_low && !tx_valid && !seen_start && brk_cnt > 0) mab_cnt++;
      if (tx_valid) seen_start = 1'b1;
      if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
      if (ram_rd) addr_q.push_back(int'(ram_addr));
      if (frame_done) done_cnt++;
      if (overrun) ovr_cnt++;
      if (prev_valid && !prev_ready && (!tx_valid || tx_data !== prev_data)) viol++;
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bytes_q.delete();
    addr_q.delete();
    brk_cnt = 0; mab_cnt = 0; done_cnt = 0; ovr_cnt = 0; viol = 0;
    seen_start = 1'b0;
  endtask

  function automatic logic [22:0] all_outs();
    return {ram_rd, ram_addr, tx_data, tx_valid, line_force_low, busy, frame_done, overrun};
  endfunction

  // ovr_at / en_drop_at: cycle after BREAK entry for a second tick / enable drop (0 = none)
  task automatic run_frame(input string tag, input logic [7:0] sc, input logic [9:0] cnt,
                           input int ovr_at, input int en_drop_at, input bit stall1,
                           input bit keep_ram);
    int n, cyc, st;
    bit stalled;
    logic [7:0] exp_q [$];
    if (!keep_ram) for (int i = 0; i < NSLOT; i++) ram[i] = 8'($urandom);
    n = (cnt == 10'd0 || int'(cnt) > NSLOT) ? NSLOT : int'(cnt);
    exp_q.push_back(sc);
    for (int i = 0; i < n; i++) exp_q.push_back(ram[i]);

    clear_mon();
    @(posedge clk_In); #1;
    force_rdy = 1'b1; enable = 1'b1; start_code = sc; slot_count = cnt; frame_tick = 1'b1;
    @(posedge clk_In); #1;
    frame_tick = 1'b0; force_rdy = 1'b0;
    start_code = 8'($urandom); slot_count = 10'($urandom);
    chk_eq({tag, "_break_at_t1"}, {30'd0, busy, line_force_low}, 32'd3);

    cyc = 0; st = 0; stalled = 1'b0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk_In); #1;
      cyc++;
      frame_tick = (ovr_at > 0 && cyc == ovr_at);
      if (ovr_at > 0 && cyc == ovr_at + 1) chk_eq({tag, "_ovr_pulse"}, overrun, 1);
      if (ovr_at > 0 && cyc == ovr_at + 2) chk_eq({tag, "_ovr_end"}, overrun, 0);
      if (en_drop_at > 0 && cyc == en_drop_at) enable = 1'b0;
      if (stall1 && !stalled && bytes_q.size() == 1) begin
        hold_low = 1'b1; stalled = 1'b1; st = cyc;
      end
      if (stalled && hold_low && cyc == st + 50) begin
        chk_eq({tag, "_stall_valid"}, tx_valid, 1);
        chk_eq({tag, "_stall_data"}, tx_data, exp_q[1]);
        hold_low = 1'b0;
      end
    end
    frame_tick = 1'b0; hold_low = 1'b0;
    chk_eq({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) @(posedge clk_In);
    #1;
    chk_eq({tag, "_busy_fell"}, busy, 0);
    chk_eq({tag, "_break_len"}, brk_cnt, BREAK_CYC);
    chk_eq({tag, "_mab_len"}, mab_cnt, MAB_CYC);
    chk_eq({tag, "_byte_count"}, bytes_q.size(), n + 1);
    chk_eq({tag, "_addr_count"}, addr_q.size(), n);
    for (int i = 0; i <= n && i < bytes_q.size(); i++)
      chk_eq($sformatf("%s_byte%0d", tag, i), bytes_q[i], exp_q[i]);
    for (int i = 0; i < n && i < addr_q.size(); i++)
      chk_eq($sformatf("%s_addr%0d", tag, i), addr_q[i], i);
    chk_eq({tag, "_done_once"}, done_cnt, 1);
    chk_eq({tag, "_overruns"}, ovr_cnt, (ovr_at > 0) ? 1 : 0);
    chk_eq({tag, "_valid_rule"}, viol, 0);
    enable = 1'b1;
  endtask

  initial begin
    #12;
    chk_eq("reset_outs", all_outs(), 0);
    @(posedge clk_In); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_In);

    ram[0] = 8'hAA; ram[1] = 8'h55; ram[2] = 8'hFF;
    run_frame("t1", 8'h00, 10'd3, 0, 0, 1'b0, 1'b1);
    run_frame("t2", 8'h00, 10'd3, 0, 0, 1'b1, 1'b1);
    run_frame("t3", 8'($urandom), 10'd10, 1000, 0, 1'b0, 1'b0);
    run_frame("t4a", 8'($urandom), 10'd0, 0, 0, 1'b0, 1'b0);
    run_frame("t4b", 8'($urandom), 10'd600, 0, 0, 1'b0, 1'b0);

    clear_mon();
    @(posedge clk_In); #1;
    force_rdy = 1'b1; enable = 1'b1; start_code = 8'h5A; slot_count = 10'd4; frame_tick = 1'b1;
    @(posedge clk_In); #1;
    frame_tick = 1'b0; force_rdy = 1'b0;
    repeat (BREAK_CYC + 60) @(posedge clk_In);
    #4;
    chk_eq("t5_in_mab", {30'd0, busy, line_force_low}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_async_outs", all_outs(), 0);
    repeat (2) @(posedge clk_In);
    #3;
    rst_n = 1'b1;
    run_frame("t5", 8'($urandom), 10'd5, 0, 0, 1'b0, 1'b0);

    clear_mon();
    @(posedge clk_In); #1;
    enable = 1'b0; frame_tick = 1'b1;
    @(posedge clk_In); #1;
    frame_tick = 1'b0;
    repeat (20) @(posedge clk_In);
    #1;
    chk_eq("t6_no_frame", busy, 0);
    chk_eq("t6_no_break", brk_cnt, 0);
    chk_eq("t6_no_overrun", ovr_cnt, 0);
    run_frame("t6", 8'($urandom), 10'd6, 0, 500, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++)
      run_frame($sformatf("rnd%0d", k), 8'($urandom), 10'($urandom_range(1, 40)), 0, 0,
                1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
